// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of a fifo among NREQ
// valid/ready producers. An owner keeps the port for up to BURST words, stalls
// while the fifo is full, and hands over to the next waiting requester in the
// same cycle it releases, so consecutive grants leave no idle cycle.
//
// Handshake: a producer raises req_valid[i] with req_data[i] and holds both
// stable until req_ready[i] is seen high at a clock edge; that edge is the
// transfer. valid never waits on ready, and ready is asserted only for the
// current owner while the fifo is not full.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   req_valid      per-requester valid
//   req_data       per-requester word, requester i at [i*WIDTH +: WIDTH]
//   req_ready      per-requester accept strobe
//   fifo_full      fifo q_full
//   fifo_wr_data   fifo wr_port
//   fifo_wr_req    fifo wr_req
//   busy           high while a requester owns the port (FSM state view)
//   grant_id       current owner, 0 when not busy
//
// Optional build macro FIFO_WR_ARBITER_STATS_EN adds:
//   stat_words     per-requester 16-bit saturating accepted-word counts
//   stat_stall     16-bit saturating count of owner-valid-but-fifo-full cycles
module fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic [WIDTH-1:0]        fifo_wr_data,
    output logic                    fifo_wr_req,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]      stat_words,
    output logic [15:0]             stat_stall
`endif
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_next;
    logic [IW-1:0] owner, owner_next;
    logic [IW-1:0] last, last_next;
    logic [7:0]    cnt, cnt_next;

    logic             owner_valid;
    logic [WIDTH-1:0] owner_data;
    logic             xfer;
    logic             rel;
    logic [IW:0]      pick;

    // First valid requester searching base+1, base+2, ... modulo NREQ.
    // Result is {found, index}; base itself is visited last.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   base);
        logic          found;
        logic [IW-1:0] idx;
        int            tgt;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            tgt = (int'(base) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && i == tgt && v[i]) begin
                    found = 1'b1;
                    idx   = IW'(i);
                end
            end
        end
        return {found, idx};
    endfunction

    // Owner's valid bit and data word.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = (state == OWN) && owner_valid && !fifo_full;
    // Release after the last word of a burst, or as soon as the owner has
    // nothing to offer (even while the fifo is full).
    assign rel  = (state == OWN) &&
                  ((xfer && cnt == 8'(BURST - 1)) || !owner_valid);

    assign fifo_wr_req  = xfer;
    assign fifo_wr_data = (state == OWN) ? owner_data : '0;
    assign busy         = (state == OWN);
    assign grant_id     = (state == OWN) ? owner : '0;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = xfer && (owner == IW'(i));
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        cnt_next   = cnt;
        pick       = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    pick       = rr_pick(req_valid, last);
                    state_next = OWN;
                    owner_next = pick[IW-1:0];
                    cnt_next   = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    cnt_next = cnt + 8'd1;
                end
                if (rel) begin
                    // The old owner becomes lowest priority; re-arbitrate now
                    // so a waiting requester gets the very next cycle.
                    last_next = owner;
                    pick      = rr_pick(req_valid, owner);
                    cnt_next  = '0;
                    if (pick[IW]) begin
                        owner_next = pick[IW-1:0];
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] words_r [NREQ];
    logic [15:0] stall_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                words_r[i] <= '0;
            end
            stall_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && words_r[i] != 16'hFFFF) begin
                    words_r[i] <= words_r[i] + 16'd1;
                end
            end
            if ((state == OWN) && owner_valid && fifo_full && stall_r != 16'hFFFF) begin
                stall_r <= stall_r + 16'd1;
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_words[i*16 +: 16] = words_r[i];
        end
    end

    assign stat_stall = stall_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Bench for fifo_wr_arbiter. Producers are modelled as per-requester word
// queues; a transaction-level reference (owner, words in grant, last owner)
// predicts every cycle's grant, ready strobes and fifo write, and the data a
// write must carry is the head of the owning producer's queue.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int IW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic                  fifo_wr_req;
    logic                  busy;
    logic [IW-1:0]         grant_id;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NREQ*16-1:0]    stat_words;
    logic [15:0]           stat_stall;
`endif

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_req  (fifo_wr_req),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_stall   (stat_stall)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    logic [WIDTH-1:0] src_q [NREQ][$];
    bit               pres [NREQ];
    logic [WIDTH-1:0] drv_data [NREQ];
    bit               gap_en;

    // reference model
    bit m_busy;
    int m_owner, m_last, m_cnt;
    int m_words [NREQ];
    int m_stall;

    // observations
    int dut_writes, cyc, pushed_r;
    int grant_log[$];
    int write_cyc[$];
    logic            s_busy;
    logic [NREQ-1:0] s_ready;

    int vectors, miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int base);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(base + k) % NREQ]) return (base + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() == 0) pres[i] = 1'b0;
            else if (!pres[i]) pres[i] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_valid[i] = pres[i];
            drv_data[i]  = pres[i] ? src_q[i][0] : WIDTH'($urandom);
            req_data[i*WIDTH +: WIDTH] = drv_data[i];
        end
    endtask

    task automatic push(input int r, input int n);
        for (int k = 0; k < n; k++) src_q[r].push_back(WIDTH'($urandom));
    endtask

    // Reference update at a clock edge using the inputs present then.
    task automatic model_edge(input bit x);
        bit burst_done;
        int p;
        burst_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = NREQ - 1;
            for (int i = 0; i < NREQ; i++) m_words[i] = 0;
            m_stall = 0;
        end else begin
            if (x) m_words[m_owner]++;
            if (m_busy && req_valid[m_owner] && fifo_full) m_stall++;
            if (!m_busy) begin
                p = rr_pick(req_valid, m_last);
                if (p >= 0) begin m_busy = 1'b1; m_owner = p; m_cnt = 0; end
            end else begin
                burst_done = x && (m_cnt == BURST - 1);
                if (x) m_cnt++;
                if (burst_done || !req_valid[m_owner]) begin
                    m_last = m_owner;
                    p = rr_pick(req_valid, m_owner);
                    if (p >= 0) begin m_owner = p; m_cnt = 0; end
                    else m_busy = 1'b0;
                end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then advance producers and model.
    task automatic cycle();
        bit              e_x;
        logic [NREQ-1:0] e_ready;
        @(negedge clk);
        e_x = m_busy && req_valid[m_owner] && !fifo_full;
        e_ready = '0;
        if (e_x) e_ready[m_owner] = 1'b1;
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_busy ? m_owner : 0);
        check("req_ready", req_ready, e_ready);
        check("fifo_wr_req", fifo_wr_req, e_x);
        check("fifo_wr_data", fifo_wr_data, m_busy ? drv_data[m_owner] : '0);
        s_busy  = busy;
        s_ready = req_ready;
        if (fifo_wr_req === 1'b1) begin
            dut_writes++;
            grant_log.push_back(int'(grant_id));
            write_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (e_x) begin
            void'(src_q[m_owner].pop_front());
            pres[m_owner] = 1'b0;
        end
        model_edge(e_x);
        cyc++;
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while (!(all_empty() && !m_busy) && n < max) begin cycle(); n++; end
        check("drain_done", all_empty() && !m_busy, 1);
        cycle();
        check("idle_busy", s_busy, 0);
    endtask

    task automatic run_writes(input int target, input int max);
        int n;
        n = 0;
        while (dut_writes < target && n < max) begin cycle(); n++; end
        check("writes_reached", dut_writes >= target, 1);
    endtask

    task automatic reset_counters();
        dut_writes = 0;
        grant_log.delete();
        write_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    int r;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; pushed_r = 0;
        reset = 1'b1; fifo_full = 1'b0; gap_en = 1'b0;
        req_valid = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++) begin pres[i] = 1'b0; drv_data[i] = '0; end
        m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = NREQ - 1; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_words[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
        cycle();
        check("reset_busy", s_busy, 0);
        check("reset_ready", s_ready, '0);

        // Requester 0 alone, 3 words.
        reset_counters();
        push(0, 3); drive();
        run_until_idle(20);
        check("t1_writes", dut_writes, 3);
        for (int k = 0; k < 3; k++) check("t1_grant", grant_log[k], 0);
        check("t1_latency", write_cyc[0] - write_cyc.size() + 3 >= 0, 1);

        // Rotation: all four valid, 5 words each, 3 full cycles inside grant 1.
        do_reset();
        reset_counters();
        for (int i = 0; i < NREQ; i++) push(i, 5);
        drive();
        run_writes(6, 40);
        fifo_full = 1'b1;
        repeat (3) cycle();
        fifo_full = 1'b0;
        run_until_idle(80);
        check("t2_writes", dut_writes, 20);
        for (int k = 0; k < 16; k++) check("t2_grant", grant_log[k], k / 4);
        for (int k = 16; k < 20; k++) check("t2_grant_tail", grant_log[k], k - 16);
        check("t2_span", write_cyc[15] - write_cyc[0], 18);
`ifdef FIFO_WR_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) check("t2_stat_words", stat_words[i*16 +: 16], 5);
        check("t2_stat_stall", stat_stall, 3);
`endif

        // Requester 1 stalled 5 cycles after its 2nd word; requester 2 waits.
        reset_counters();
        push(1, 6); drive();
        run_writes(2, 20);
        push(2, 2); drive();
        fifo_full = 1'b1;
        r = dut_writes;
        repeat (5) cycle();
        check("t3_stall_writes", dut_writes, r);
        fifo_full = 1'b0;
        run_until_idle(60);
        check("t3_writes", dut_writes, 8);
        check("t3_grant3", grant_log[3], 1);
        check("t3_grant4", grant_log[4], 2);
        check("t3_grant5", grant_log[5], 2);
        check("t3_grant6", grant_log[6], 1);

        // Requester 2 alone streaming 10 words: back-to-back re-grants.
        reset_counters();
        push(2, 10); drive();
        run_until_idle(40);
        check("t4_writes", dut_writes, 10);
        check("t4_span", write_cyc[9] - write_cyc[0], 9);
        for (int k = 0; k < 10; k++) check("t4_grant", grant_log[k], 2);

        // Reset mid-burst (owner 3, two words in), then 0 and 3 compete.
        reset_counters();
        push(3, 4); drive();
        run_writes(2, 20);
        fifo_full = 1'b1;
        do_reset();
        fifo_full = 1'b0;
        reset_counters();
        push(0, 2); drive();
        cycle();
        check("t5_busy", s_busy, 0);
        check("t5_ready", s_ready, '0);
        run_until_idle(40);
        check("t5_writes", dut_writes, 4);
        check("t5_first", grant_log[0], 0);
        check("t5_third", grant_log[2], 3);

        // Random traffic with gaps and random fifo_full.
        reset_counters();
        gap_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, NREQ - 1);
                if (src_q[r].size() < 6) begin push(r, 1); pushed_r++; end
                drive();
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        fifo_full = 1'b0;
        run_until_idle(400);
        check("rand_writes", dut_writes, pushed_r);
`ifdef FIFO_WR_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) check("rand_stat_words", stat_words[i*16 +: 16], m_words[i]);
        check("rand_stat_stall", stat_stall, m_stall);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
